// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter
// Shares the single-port data RAM (1-cycle synchronous read, byte-lane write
// enables) between the CPU load/store port and a word-wide DMA/debug port.
// CPU has priority, but after STARVE_LIMIT consecutive CPU grants while the
// DMA is waiting, one DMA grant is forced.
//
// Ports:
//   clk, rst (sync, active-low)
//   cpu_*  : request/size/address/store data in; gnt, rvalid, rdata, err out
//   dma_*  : word request in; gnt, rvalid, rdata out
//   ram_*  : wea (byte lanes), addr (word), din to the RAM; dout from the RAM
//
// Optional build macro RISCV_DMEM_ARB_LOAD_EXT_EN: CPU loads return the
// addressed byte/half, sign- or zero-extended. Without it, cpu_rdata is the
// raw RAM word and cpu_unsigned is ignored.
module riscv_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  owner_t            owner_q;
  logic              err_q;
  logic [3:0]        streak_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dma_rdata_q;

  logic        cpu_bad;
  logic        starve;
  logic        cpu_ram_gnt;   // CPU granted and actually using the RAM
  logic        cpu_err_gnt;   // CPU granted with an error, RAM left free
  logic        dma_ram_gnt;
  logic [3:0]  cpu_strb;
  logic [31:0] cpu_store;
  logic [31:0] cpu_load;

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[31:ADDR_W+2], cpu_unsigned};

  always_comb begin
    cpu_bad = (cpu_size == 2'b11)
            | ((cpu_size == 2'b01) & cpu_addr[0])
            | ((cpu_size == 2'b10) & (|cpu_addr[1:0]));
    starve      = dma_req & (streak_q == LIMIT);
    cpu_err_gnt = rst & cpu_req & cpu_bad;
    cpu_ram_gnt = rst & cpu_req & ~cpu_bad & ~starve;
    dma_ram_gnt = rst & dma_req & ~cpu_ram_gnt;
    cpu_gnt     = cpu_err_gnt | cpu_ram_gnt;
    dma_gnt     = dma_ram_gnt;
  end

  always_comb begin
    cpu_strb  = 4'b1111;
    cpu_store = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        cpu_strb  = 4'b0001 << cpu_addr[1:0];
        cpu_store = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        cpu_strb  = cpu_addr[1] ? 4'b1100 : 4'b0011;
        cpu_store = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_wea  = '0;
    ram_addr = addr_q;
    ram_din  = cpu_store;
    if (cpu_ram_gnt) begin
      ram_addr = cpu_addr[ADDR_W+1:2];
      if (cpu_we) ram_wea = cpu_strb;
    end else if (dma_ram_gnt) begin
      ram_addr = dma_addr;
      ram_din  = dma_wdata;
      if (dma_we) ram_wea = '1;
    end
  end

`ifdef RISCV_DMEM_ARB_LOAD_EXT_EN
  logic [1:0] lat_size;
  logic       lat_uns;
  logic [1:0] lat_lo;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ram_dout[7:0];
    case (lat_lo)
      2'b01:   ld_byte = ram_dout[15:8];
      2'b10:   ld_byte = ram_dout[23:16];
      2'b11:   ld_byte = ram_dout[31:24];
      default: ;
    endcase
    ld_half = lat_lo[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (lat_size)
      2'b00:   cpu_load = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
      2'b01:   cpu_load = {{16{~lat_uns & ld_half[15]}}, ld_half};
      default: cpu_load = ram_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_size <= '0;
      lat_uns  <= 1'b0;
      lat_lo   <= '0;
    end else if (cpu_ram_gnt) begin
      lat_size <= cpu_size;
      lat_uns  <= cpu_unsigned;
      lat_lo   <= cpu_addr[1:0];
    end
  end
`else
  always_comb cpu_load = ram_dout;
`endif

  // Response outputs are gated by rst so an in-flight read is dropped as soon
  // as reset is asserted, not one cycle later.
  always_comb begin
    cpu_rvalid = rst & ((owner_q == OWN_CPU) | err_q);
    cpu_err    = rst & err_q;
    dma_rvalid = rst & (owner_q == OWN_DMA);
    cpu_rdata  = (rst & (owner_q == OWN_CPU)) ? cpu_load : cpu_rdata_q;
    dma_rdata  = dma_rvalid ? ram_dout : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      err_q       <= 1'b0;
      streak_q    <= '0;
      addr_q      <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (!dma_req || dma_ram_gnt)
        streak_q <= '0;
      else if (cpu_ram_gnt && streak_q != LIMIT)
        streak_q <= streak_q + 4'd1;

      if (cpu_ram_gnt && !cpu_we)      owner_q <= OWN_CPU;
      else if (dma_ram_gnt && !dma_we) owner_q <= OWN_DMA;
      else                             owner_q <= OWN_NONE;

      err_q <= cpu_err_gnt;

      if (cpu_ram_gnt || dma_ram_gnt) addr_q <= ram_addr;
      if (owner_q == OWN_CPU) cpu_rdata_q <= cpu_rdata;
      if (owner_q == OWN_DMA) dma_rdata_q <= dma_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter
// Scoreboard bench: the driver predicts grants/RAM signals from the arbitration
// rules and pushes expected read responses into queues; a monitor pops them
// when the response cycle arrives. A behavioural RAM sits on the ram_* port.
module tb_riscv_dmem_arbiter;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned AW    = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]    cpu_size;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [31:0]   dma_rdata;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(int a);
    if (a == 4) return 32'h8899AABB;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural RAM device
  logic [31:0] mem [int];
  always @(posedge clk) begin : ram_dev
    logic [31:0] w;
    int a;
    a = int'(ram_addr);
    w = mem.exists(a) ? mem[a] : init_word(a);
    ram_dout <= w;
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) w[8*i +: 8] = ram_din[8*i +: 8];
    if (|ram_wea) mem[a] = w;
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  typedef struct { int due; bit err; logic [31:0] data; } resp_t;
  resp_t cq[$];
  resp_t dq[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          streak_m = 0;
  logic [AW-1:0] last_addr;
  bit          addr_known = 0;
  bit          last_cg = 0, last_dg = 0;
  bit          log_en = 0;
  string       gnt_log = "";
  logic [31:0] last_cpu, last_dma;
  bit          cpu_hold_known = 0, dma_hold_known = 0;

  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] load_value(logic [31:0] a, logic [1:0] sz, logic uns);
    logic [31:0] w, v, mask;
    int nb;
    w = ref_rd(int'(a[AW+1:2]));
`ifdef RISCV_DMEM_ARB_LOAD_EXT_EN
    if (sz == 2'd2) return w;
    nb   = 1 << sz;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v    = (w >> (8 * (a % 4))) & mask;
    if (!uns && ((v >> (8 * nb - 1)) & 32'h1) != 0) v = v | ~mask;
    return v;
`else
    nb = int'(sz) + int'(uns);
    v = w; mask = 32'(nb);
    return v;
`endif
  endfunction

  task automatic predict();
    bit bad, ec, ed;
    int nb, wa;
    logic [3:0]  ewea;
    logic [31:0] edin, w;
    logic [AW-1:0] eaddr;
    resp_t r;
    if (!rst) begin
      chk("cpu_gnt_in_reset", cpu_gnt, 0);
      chk("dma_gnt_in_reset", dma_gnt, 0);
      chk("ram_wea_in_reset", ram_wea, 0);
      streak_m = 0; addr_known = 0; last_cg = 0; last_dg = 0;
      return;
    end
    nb  = 1 << cpu_size;
    bad = cpu_req && (cpu_size == 2'd3 || (cpu_addr % nb) != 0);
    if (!cpu_req)  begin ec = 0; ed = dma_req; end
    else if (bad)  begin ec = 1; ed = dma_req; end
    else begin
      ec = !(dma_req && streak_m == LIMIT);
      ed = dma_req && !ec;
    end
    chk("cpu_gnt", cpu_gnt, 32'(ec));
    chk("dma_gnt", dma_gnt, 32'(ed));
    if (log_en) gnt_log = {gnt_log, (ec && !bad) ? "C" : (ed ? "D" : "-")};

    ewea = '0; edin = '0; eaddr = '0;
    if (ec && !bad) begin
      eaddr = cpu_addr[AW+1:2];
      if (cpu_we) begin
        ewea = 4'(((1 << nb) - 1) << (cpu_addr % 4));
        edin = (cpu_size == 0) ? 32'(cpu_wdata[7:0]) * 32'h01010101 :
               (cpu_size == 1) ? 32'(cpu_wdata[15:0]) * 32'h00010001 : cpu_wdata;
      end else begin
        r.due = cyc + 1; r.err = 0;
        r.data = load_value(cpu_addr, cpu_size, cpu_unsigned);
        cq.push_back(r);
      end
    end else if (ed) begin
      eaddr = dma_addr;
      if (dma_we) begin ewea = 4'hF; edin = dma_wdata; end
      else begin
        r.due = cyc + 1; r.err = 0; r.data = ref_rd(int'(dma_addr));
        dq.push_back(r);
      end
    end
    if (ec && bad) begin
      r.due = cyc + 1; r.err = 1; r.data = '0;
      cq.push_back(r);
    end

    chk("ram_wea", ram_wea, 32'(ewea));
    if (ewea != 0) begin
      chk("ram_din", ram_din, edin);
      wa = int'(eaddr);
      w  = ref_rd(wa);
      for (int i = 0; i < 4; i++) if (ewea[i]) w[8*i +: 8] = edin[8*i +: 8];
      ref_mem[wa] = w;
    end
    if ((ec && !bad) || ed) begin
      chk("ram_addr", 32'(ram_addr), 32'(eaddr));
      last_addr = eaddr; addr_known = 1;
    end else if (addr_known) begin
      chk("ram_addr_hold", 32'(ram_addr), 32'(last_addr));
    end

    if (!dma_req || ed) streak_m = 0;
    else if (ec && !bad && streak_m < LIMIT) streak_m++;
    last_cg = ec; last_dg = ed;
  endtask

  // Monitor: compares responses whenever their cycle comes up
  initial forever begin
    resp_t e;
    @(posedge clk); #2;
    if (cq.size() != 0 && cq[0].due == cyc) begin
      e = cq.pop_front();
      chk("cpu_rvalid", cpu_rvalid, 1);
      chk("cpu_err", cpu_err, 32'(e.err));
      if (!e.err) begin
        chk("cpu_rdata", cpu_rdata, e.data);
        last_cpu = e.data; cpu_hold_known = 1;
      end
    end else begin
      chk("cpu_rvalid_idle", cpu_rvalid, 0);
      if (cpu_hold_known) chk("cpu_rdata_hold", cpu_rdata, last_cpu);
    end
    if (dq.size() != 0 && dq[0].due == cyc) begin
      e = dq.pop_front();
      chk("dma_rvalid", dma_rvalid, 1);
      chk("dma_rdata", dma_rdata, e.data);
      last_dma = e.data; dma_hold_known = 1;
    end else begin
      chk("dma_rvalid_idle", dma_rvalid, 0);
      if (dma_hold_known) chk("dma_rdata_hold", dma_rdata, last_dma);
    end
  end

  task automatic tick();
    @(negedge clk);
    predict();
    @(posedge clk); #1;
  endtask

  task automatic start_reset();
    rst = 1'b0;
    cq.delete(); dq.delete();
    cpu_hold_known = 0; dma_hold_known = 0;
  endtask

  task automatic cpu_set(logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] wd);
    cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic dma_set(logic we, logic [AW-1:0] a, logic [31:0] wd);
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd;
  endtask

  task automatic cpu_op(logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] wd);
    cpu_set(we, sz, uns, a, wd);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_cg) break;
    end
    chk("cpu_op_granted", 32'(last_cg), 1);
    cpu_req = 0;
  endtask

  initial begin
    rst = 0;
    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    @(posedge clk); #1;
    start_reset();
    repeat (3) tick();
    chk("cpu_rvalid_after_reset", cpu_rvalid, 0);
    chk("cpu_err_after_reset", cpu_err, 0);
    rst = 1;

    // Byte store replicates data onto lane 2 of word 1
    cpu_op(1, 2'd0, 0, 32'h6, 32'h000000A5);
    // Loads from word 4 (preset 0x8899AABB)
    cpu_op(0, 2'd2, 0, 32'h10, 0);
    cpu_op(0, 2'd0, 0, 32'h13, 0);
    cpu_op(0, 2'd0, 1, 32'h13, 0);
    cpu_op(0, 2'd1, 0, 32'h12, 0);
    cpu_op(0, 2'd1, 1, 32'h10, 0);
    cpu_op(0, 2'd1, 0, 32'h4, 0);

    // Starvation bound with both ports requesting continuously
    log_en = 1; gnt_log = "";
    cpu_set(0, 2'd2, 0, 32'h0, 0);
    dma_set(0, 14'd3, 0);
    repeat (10) tick();
    log_en = 0; cpu_req = 0; dma_req = 0;
    checks++;
    if (gnt_log != "CCCCDCCCCD") begin
      errors++;
      $display("FAIL grant_sequence: got %s expected CCCCDCCCCD", gnt_log);
    end

    // Misaligned half load alongside a DMA write in the same cycle
    cpu_set(0, 2'd1, 0, 32'h1, 0);
    dma_set(1, 14'd5, 32'hCAFEF00D);
    tick();
    cpu_req = 0; dma_req = 0;
    cpu_op(1, 2'd3, 0, 32'h8, 32'h12345678);
    cpu_op(1, 2'd2, 0, 32'h22, 32'h12345678);
    cpu_op(0, 2'd0, 0, 32'h14, 0);

    // Alternating CPU/DMA reads, back to back
    repeat (3) begin
      cpu_set(0, 2'd2, 0, 32'h4, 0);
      tick();
      cpu_req = 0;
      dma_set(0, 14'd8, 0);
      tick();
      dma_req = 0;
    end

    // Reset with a DMA read in flight
    dma_set(0, 14'd2, 0);
    tick();
    dma_req = 0;
    start_reset();
    tick();
    chk("dma_rvalid_after_reset", dma_rvalid, 0);
    chk("cpu_rvalid_after_reset2", cpu_rvalid, 0);
    chk("cpu_err_after_reset2", cpu_err, 0);
    tick();
    rst = 1;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || last_cg) begin
        if ($urandom_range(0, 3) != 0)
          cpu_set(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        else cpu_req = 0;
      end
      if (!dma_req || last_dg) begin
        if ($urandom_range(0, 2) == 0)
          dma_set(1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), $urandom);
        else dma_req = 0;
      end
      tick();
    end
    cpu_req = 0; dma_req = 0;
    repeat (3) tick();
    chk("cpu_queue_drained", 32'(cq.size()), 0);
    chk("dma_queue_drained", 32'(dq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
